// File: rtl/pmod_button_debouncer_if.sv
// Pin-side and event-stream signals of the PMOD button debouncer.
// master = the debouncer (producer of levels and events), slave = the consumer.
interface pmod_button_debouncer_if #(
    parameter int N_CH = 8
);
    logic [N_CH-1:0] pmod_in;
    logic [N_CH-1:0] state;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic            evt_valid;
    logic [2:0]      evt_ch;
    logic            evt_press;
    logic            evt_ready;
    logic            evt_ovf;

    modport master (
        input  pmod_in,
        input  evt_ready,
        output state,
        output press_pulse,
        output release_pulse,
        output evt_valid,
        output evt_ch,
        output evt_press,
        output evt_ovf
    );

    modport slave (
        output pmod_in,
        output evt_ready,
        input  state,
        input  press_pulse,
        input  release_pulse,
        input  evt_valid,
        input  evt_ch,
        input  evt_press,
        input  evt_ovf
    );
endinterface

// File: rtl/pmod_button_debouncer.sv
// Synchronises and debounces up to 8 PMOD buttons, emits press/release pulses and
// serialises them into a valid/ready event stream with a sticky overflow flag.
module pmod_button_debouncer #(
    parameter int N_CH            = 8,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    pmod_button_debouncer_if.master       bus
);
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Inactive pin level doubles as the polarity mask applied after synchronisation.
    localparam logic [N_CH-1:0]  INV      = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

    logic [N_CH-1:0] sync1_reg;
    logic [N_CH-1:0] sync2_reg;
    logic [N_CH-1:0] lvl;
    logic [N_CH-1:0] commit;
    logic [N_CH-1:0] state_reg;
    logic [N_CH-1:0] press_reg;
    logic [N_CH-1:0] release_reg;

    logic [N_CH-1:0] pend_p_reg;
    logic [N_CH-1:0] pend_r_reg;
    logic [N_CH-1:0] pend_p_next;
    logic [N_CH-1:0] pend_r_next;
    logic [N_CH-1:0] clr_p;
    logic [N_CH-1:0] clr_r;
    logic            accept;
    logic            lost;
    logic            sel_any;
    logic [2:0]      sel_ch;
    logic            sel_press;

    logic            evt_valid_reg;
    logic [2:0]      evt_ch_reg;
    logic            evt_press_reg;
    logic            evt_ovf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= INV;
            sync2_reg <= INV;
        end else begin
            sync1_reg <= bus.pmod_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign lvl = sync2_reg ^ INV;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;

            assign commit[gi] = (lvl[gi] != state_reg[gi]) && (cnt_reg == CNT_LAST);

            // Any sample matching the accepted level restarts the hold period.
            always_ff @(posedge clk) begin
                if (rst || (lvl[gi] == state_reg[gi]) || commit[gi]) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= '0;
            press_reg   <= '0;
            release_reg <= '0;
        end else begin
            state_reg   <= state_reg ^ commit;
            press_reg   <= commit & lvl;
            release_reg <= commit & ~lvl;
        end
    end

    always_comb begin
        accept = evt_valid_reg & bus.evt_ready;
        clr_p  = '0;
        clr_r  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (accept && (evt_ch_reg == 3'(i))) begin
                if (evt_press_reg) begin
                    clr_p[i] = 1'b1;
                end else begin
                    clr_r[i] = 1'b1;
                end
            end
        end

        // A same-cycle set wins over the accept-clear, so the pulse is never lost there.
        pend_p_next = (pend_p_reg & ~clr_p) | press_reg;
        pend_r_next = (pend_r_reg & ~clr_r) | release_reg;
        lost        = (|(press_reg & pend_p_reg & ~clr_p)) | (|(release_reg & pend_r_reg & ~clr_r));

        sel_any   = |(pend_p_next | pend_r_next);
        sel_ch    = '0;
        sel_press = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pend_p_next[i] || pend_r_next[i]) begin
                sel_ch    = 3'(i);
                sel_press = pend_p_next[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_p_reg    <= '0;
            pend_r_reg    <= '0;
            evt_valid_reg <= 1'b0;
            evt_ch_reg    <= '0;
            evt_press_reg <= 1'b0;
            evt_ovf_reg   <= 1'b0;
        end else begin
            pend_p_reg  <= pend_p_next;
            pend_r_reg  <= pend_r_next;
            evt_ovf_reg <= evt_ovf_reg | lost;
            // A presented event is frozen until the consumer takes it.
            if (!evt_valid_reg || accept) begin
                evt_valid_reg <= sel_any;
                evt_ch_reg    <= sel_ch;
                evt_press_reg <= sel_press;
            end
        end
    end

    assign bus.state         = state_reg;
    assign bus.press_pulse   = press_reg;
    assign bus.release_pulse = release_reg;
    assign bus.evt_valid     = evt_valid_reg;
    assign bus.evt_ch        = evt_ch_reg;
    assign bus.evt_press     = evt_press_reg;
    assign bus.evt_ovf       = evt_ovf_reg;
endmodule
